bank_rr_arbiter: RTL and testbench
==================================

// Module: bank_rr_arbiter
// PURPOSE
//  Per-memory-bank round-robin arbiter, directly downstream of the PEA-side synch_fifo instances.
//  Collects bit BANK_ID of every FIFO's req_pea_to_bank and the head word each FIFO presents on read_data.
//  Returns a one-cycle grant that the FIFO uses as nxt_gnt, and drives one registered access per transfer to the bank.
//  One instance per bank; MEM_BANK_NUM instances together form the crossbar arbitration layer.
// PARAMETERS
//  NUM_REQ     16  number of requesting FIFOs (PEA ports)
//  DATA_WIDTH  32  payload width (low bits of a FIFO word)
//  BID_WIDTH   4   target-bank field width (FIFO word bits [DATA_WIDTH+BID_WIDTH-1:DATA_WIDTH])
//  BANK_ID     0   bank index this instance serves
//  SRC_W       4   clog2(NUM_REQ), width of the source index
// PORTS
//  clk          in   1                          clock
//  rst_n        in   1                          asynchronous reset, active-low
//  req          in   NUM_REQ                    req[i] = FIFO i head targets this bank
//  req_word     in   NUM_REQ*(DATA_WIDTH+BID_WIDTH)  flattened FIFO head words; slice i belongs to FIFO i
//  bank_ready   in   1                          bank accepts the current access this cycle
//  gnt          out  NUM_REQ                    one-hot, one-cycle pop to the winning FIFO (nxt_gnt)
//  bank_valid   out  1                          access pending towards the bank
//  bank_data    out  DATA_WIDTH                 payload of the pending access
//  bank_src     out  SRC_W                      FIFO index of the pending access
//  err_misroute out  1                          sticky: a granted word carried BID != BANK_ID
//  grant_count  out  16                         granted-word counter; wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset values: gnt=0, bank_valid=0, bank_data=0, bank_src=0, err_misroute=0, grant_count=0.
//  Reset also forces state=IDLE and last=NUM_REQ-1, so index 0 has first priority.
//  States:
//   IDLE  - no access pending.
//   ISSUE - gnt pulse cycle; bank_valid=1.
//   STALL - bank_valid=1, gnt=0, waiting for bank_ready.
//  Eligible set: elig = req & ~gnt.
//   - Masking the current gnt bit blocks a double grant while the FIFO's registered req lags its pop by one cycle.
//  Pick: first set bit of elig searched from (last+1) mod NUM_REQ upward, with wrap-around.
//   - Example: last=15 with req[15] and req[0] set -> 0 wins.
//  Arbitration is evaluated in IDLE, and in ISSUE/STALL on a cycle where bank_ready=1.
//   - Winner w found: next cycle state=ISSUE, gnt=onehot(w), last=w, bank_src=w, grant_count+1.
//     bank_data is captured from the data field of slice w.
//   - No winner: next state=IDLE, bank_valid=0.
//  Latency: req at cycle t -> gnt and bank_valid at t+1. Sustained throughput is 1 word/cycle across different requesters.
//  ISSUE, bank_ready=0 -> STALL.
//   - gnt drops after exactly one cycle; bank_data and bank_src are held stable until bank_ready=1.
//  Misroute: winner's BID field != BANK_ID.
//   - gnt still pulses so the FIFO drains, and grant_count still increments.
//   - bank_valid stays 0 for that word; err_misroute sets and holds until reset.
//  Reset asserted mid-ISSUE/STALL: the pending access is discarded immediately and all outputs return to reset values.
//  gnt is always one-hot or zero. At most one gnt bit is high in any cycle.
// STRUCTURE
//  Shared cgra_mem_pkg.vh holds:
//   - state encodings ST_IDLE, ST_ISSUE, ST_STALL
//   - the word-field macros for BID and DATA slice positions
//   - MEM_BANK_NUM
//  Sub-module rr_priority_pick: combinational rotate, find-first-one, un-rotate.
//   - Inputs elig and last; outputs found and idx.
//   - Reused by future read-return arbitration.
//  This module holds the FSM, last pointer, output registers and counter.
// TESTING
//  1. req=16'h0008 for 1 cycle, slice3={4'd0,32'hCAFE0003}, bank_ready=1.
//     -> gnt=0x0008 one cycle at t+1; bank_valid=1, bank_data=CAFE0003, bank_src=3; grant_count=1.
//  2. req bits 0,5,9 held high, bank_ready=1.
//     -> gnt sequence 0x0001, 0x0020, 0x0200, 0x0001 on consecutive cycles; no repeated index back-to-back.
//  3. Single req 2, bank_ready=0 for 3 cycles after grant.
//     -> gnt high 1 cycle only; bank_valid/bank_data held 3 cycles; returns to IDLE after bank_ready=1.
//  4. BANK_ID=2, req 4 with BID=7.
//     -> gnt[4] pulses; bank_valid stays 0; err_misroute=1 and stays 1 across later legal grants.
//  5. Force last=15 via a prior grant to 15, then req bits 15 and 0.
//     -> gnt=0x0001 first, then gnt=0x8000.
//  6. rst_n low during STALL.
//     -> all outputs 0 same cycle; after release, req 0 and 1 together -> gnt=0x0001 first.

Source files
------------

// File: rtl/bank_rr_arbiter_pkg.sv
// Shared definitions for the bank arbitration layer: FSM encoding and
// crossbar-wide constants.
package bank_rr_arbiter_pkg;

   // Number of memory banks; one bank_rr_arbiter instance serves each bank.
   localparam int MEM_BANK_NUM = 16;

   // Arbiter FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_STALL = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: returns the first set bit of elig found by
// searching upward from (last+1) mod N, wrapping around. Purely combinational.
module rr_priority_pick #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] elig,
   input  logic [W-1:0] last,
   output logic         found,
   output logic [W-1:0] idx
);

   // Scan the N candidates in rotated order; the first eligible one wins.
   always_comb begin
      int j;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(last) + 1 + k;
         if (j >= N) j = j - N;
         if (j >= N) j = j - N;
         if (!found && elig[W'(j)]) begin
            found = 1'b1;
            idx   = W'(j);
         end
      end
   end

endmodule

// File: rtl/bank_rr_arbiter.sv
// Per-bank round-robin arbiter. Picks one FIFO head per transfer, pulses a
// one-cycle pop (gnt) back to that FIFO and holds a registered access towards
// the bank until the bank takes it.
//
// Bank handshake: an access is offered while bank_valid=1 and is consumed on a
// rising clk edge where bank_valid=1 and bank_ready=1; bank_data and bank_src
// are stable for the whole time bank_valid=1 and bank_ready=0.
//
// A misrouted word (BID != BANK_ID) is popped but never offered to the bank,
// so with no access pending the arbiter is free to pick again on the next
// cycle regardless of bank_ready.
module bank_rr_arbiter
   import bank_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 16,
   parameter int DATA_WIDTH = 32,
   parameter int BID_WIDTH  = 4,
   parameter int BANK_ID    = 0,
   parameter int SRC_W      = 4
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [NUM_REQ-1:0]                       req,
   input  logic [NUM_REQ*(DATA_WIDTH+BID_WIDTH)-1:0] req_word,
   input  logic                                     bank_ready,
   output logic [NUM_REQ-1:0]                       gnt,
   output logic                                     bank_valid,
   output logic [DATA_WIDTH-1:0]                    bank_data,
   output logic [SRC_W-1:0]                         bank_src,
   output logic                                     err_misroute,
   output logic [15:0]                              grant_count
);

   localparam int WORD_W = DATA_WIDTH + BID_WIDTH;

   arb_state_e            state, state_nxt;
   logic [SRC_W-1:0]      last, last_nxt;
   logic [NUM_REQ-1:0]    elig;
   logic                  found;
   logic [SRC_W-1:0]      pick;
   logic [WORD_W-1:0]     pick_word;
   logic                  can_arb;

   logic [NUM_REQ-1:0]    gnt_nxt;
   logic                  valid_nxt;
   logic [DATA_WIDTH-1:0] data_nxt;
   logic [SRC_W-1:0]      src_nxt;
   logic                  err_nxt;
   logic [15:0]           count_nxt;

   // The FIFO's req still shows the word just popped for one cycle, so the
   // bit granted this cycle is excluded from the next pick.
   assign elig = req & ~gnt;

   rr_priority_pick #(
      .N (NUM_REQ),
      .W (SRC_W)
   ) u_pick (
      .elig  (elig),
      .last  (last),
      .found (found),
      .idx   (pick)
   );

   assign pick_word = req_word[int'(pick)*WORD_W +: WORD_W];

   // Next-state and next-output logic: stall while the bank holds off an
   // offered access, otherwise arbitrate.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      gnt_nxt   = '0;
      valid_nxt = bank_valid;
      data_nxt  = bank_data;
      src_nxt   = bank_src;
      err_nxt   = err_misroute;
      count_nxt = grant_count;
      can_arb   = 1'b0;

      case (state)
         ST_IDLE: can_arb = 1'b1;
         ST_ISSUE, ST_STALL: begin
            if (bank_valid && !bank_ready) state_nxt = ST_STALL;
            else                           can_arb   = 1'b1;
         end
         default: begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
         end
      endcase

      if (can_arb) begin
         if (found) begin
            state_nxt     = ST_ISSUE;
            gnt_nxt[pick] = 1'b1;
            last_nxt      = pick;
            src_nxt       = pick;
            data_nxt      = pick_word[DATA_WIDTH-1:0];
            count_nxt     = grant_count + 16'd1;
            if (pick_word[WORD_W-1:DATA_WIDTH] != BID_WIDTH'(BANK_ID)) begin
               valid_nxt = 1'b0;
               err_nxt   = 1'b1;
            end else begin
               valid_nxt = 1'b1;
            end
         end else begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Round-robin pointer, output registers and grant counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last         <= SRC_W'(NUM_REQ - 1);
         gnt          <= '0;
         bank_valid   <= 1'b0;
         bank_data    <= '0;
         bank_src     <= '0;
         err_misroute <= 1'b0;
         grant_count  <= '0;
      end else begin
         last         <= last_nxt;
         gnt          <= gnt_nxt;
         bank_valid   <= valid_nxt;
         bank_data    <= data_nxt;
         bank_src     <= src_nxt;
         err_misroute <= err_nxt;
         grant_count  <= count_nxt;
      end
   end

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Bench for bank_rr_arbiter (BANK_ID=2): directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the round-robin rules.
module tb_bank_rr_arbiter;

   localparam int NREQ = 16;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int BANK = 2;
   localparam int SW   = 4;
   localparam int WW   = DW + BW;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req;
   logic [NREQ*WW-1:0]   req_word;
   logic                 bank_ready;
   logic [NREQ-1:0]      gnt;
   logic                 bank_valid;
   logic [DW-1:0]        bank_data;
   logic [SW-1:0]        bank_src;
   logic                 err_misroute;
   logic [15:0]          grant_count;

   int n_total = 0;
   int n_pass  = 0;

   // Behavioural model: what the outputs must be after the latest clock edge.
   logic [15:0] m_gnt;
   logic        m_valid;
   logic [31:0] m_data;
   logic [3:0]  m_src;
   logic        m_err;
   logic [15:0] m_cnt;
   int          m_last;

   bank_rr_arbiter #(
      .NUM_REQ    (NREQ),
      .DATA_WIDTH (DW),
      .BID_WIDTH  (BW),
      .BANK_ID    (BANK),
      .SRC_W      (SW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .req_word     (req_word),
      .bank_ready   (bank_ready),
      .gnt          (gnt),
      .bank_valid   (bank_valid),
      .bank_data    (bank_data),
      .bank_src     (bank_src),
      .err_misroute (err_misroute),
      .grant_count  (grant_count)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_gnt   = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = '0;
      m_err   = 1'b0;
      m_cnt   = '0;
      m_last  = NREQ - 1;
   endtask

   // One clock edge of the arbitration rules, applied to the inputs that the
   // next rising edge will sample.
   task automatic model_step();
      logic [15:0] elig;
      logic [35:0] word;
      int          w;
      if (m_valid && !bank_ready) begin
         m_gnt = '0;
         return;
      end
      elig = req & ~m_gnt;
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (m_last + 1 + k) % NREQ;
         if (w < 0 && elig[j[3:0]]) w = j;
      end
      if (w < 0) begin
         m_gnt   = '0;
         m_valid = 1'b0;
      end else begin
         word    = req_word[w*WW +: WW];
         m_gnt   = 16'd1 << w;
         m_last  = w;
         m_src   = w[3:0];
         m_data  = word[31:0];
         m_cnt   = m_cnt + 16'd1;
         if (word[35:32] != 4'(BANK)) begin
            m_valid = 1'b0;
            m_err   = 1'b1;
         end else begin
            m_valid = 1'b1;
         end
      end
   endtask

   // Compare process: check the DUT against the model on every falling edge.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         chk("cyc_gnt", gnt, m_gnt);
         chk("cyc_valid", bank_valid, m_valid);
         chk("cyc_data", bank_data, m_data);
         chk("cyc_src", bank_src, m_src);
         chk("cyc_err", err_misroute, m_err);
         chk("cyc_count", grant_count, m_cnt);
         chk("cyc_onehot", 64'($countones(gnt) <= 1), 64'd1);
         if (rst_n) model_step();
      end
   end

   // Driver step: inputs change 2 time units after a rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_word(input int i, input logic [3:0] bid, input logic [31:0] d);
      req_word[i*WW +: WW] = {bid, d};
   endtask

   task automatic expect_out(input string tag, input logic [15:0] g, input logic v,
                             input logic [31:0] d, input logic [3:0] s,
                             input logic e, input logic [15:0] c);
      chk({tag, "_gnt"}, gnt, g);
      chk({tag, "_valid"}, bank_valid, v);
      if (v) begin
         chk({tag, "_data"}, bank_data, d);
         chk({tag, "_src"}, bank_src, s);
      end
      chk({tag, "_err"}, err_misroute, e);
      chk({tag, "_count"}, grant_count, c);
   endtask

   initial begin
      rst_n      = 1'b0;
      req        = '0;
      req_word   = '0;
      bank_ready = 1'b0;
      repeat (3) tick();
      expect_out("reset", 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd0);
      chk("reset_data", bank_data, 32'h0);
      chk("reset_src", bank_src, 4'h0);
      rst_n = 1'b1;
      tick();

      // Requesters 0, 5, 9 held high: strict rotation starting at index 0.
      set_word(0, 4'd2, 32'hA0000000);
      set_word(5, 4'd2, 32'hA0000005);
      set_word(9, 4'd2, 32'hA0000009);
      req = 16'h0221;
      bank_ready = 1'b1;
      tick(); expect_out("rot1", 16'h0001, 1'b1, 32'hA0000000, 4'd0, 1'b0, 16'd1);
      tick(); expect_out("rot2", 16'h0020, 1'b1, 32'hA0000005, 4'd5, 1'b0, 16'd2);
      tick(); expect_out("rot3", 16'h0200, 1'b1, 32'hA0000009, 4'd9, 1'b0, 16'd3);
      tick(); expect_out("rot4", 16'h0001, 1'b1, 32'hA0000000, 4'd0, 1'b0, 16'd4);
      req = '0;
      tick(); expect_out("rot_idle", 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd4);

      // Single one-cycle request from FIFO 3.
      set_word(3, 4'd2, 32'hCAFE0003);
      req = 16'h0008;
      tick(); expect_out("single", 16'h0008, 1'b1, 32'hCAFE0003, 4'd3, 1'b0, 16'd5);
      req = '0;
      tick(); expect_out("single_idle", 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd5);

      // FIFO 2 granted while the bank holds off for three cycles.
      set_word(2, 4'd2, 32'h12340002);
      req = 16'h0004;
      bank_ready = 1'b0;
      tick(); expect_out("stall_gnt", 16'h0004, 1'b1, 32'h12340002, 4'd2, 1'b0, 16'd6);
      req = '0;
      tick(); expect_out("stall1", 16'h0, 1'b1, 32'h12340002, 4'd2, 1'b0, 16'd6);
      tick(); expect_out("stall2", 16'h0, 1'b1, 32'h12340002, 4'd2, 1'b0, 16'd6);
      tick(); expect_out("stall3", 16'h0, 1'b1, 32'h12340002, 4'd2, 1'b0, 16'd6);
      bank_ready = 1'b1;
      tick(); expect_out("stall_done", 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd6);

      // Wrap-around: after a grant to 15, index 0 wins before 15 again.
      set_word(15, 4'd2, 32'hF000000F);
      req = 16'h8000;
      tick(); expect_out("wrap_prime", 16'h8000, 1'b1, 32'hF000000F, 4'd15, 1'b0, 16'd7);
      req = 16'h8001;
      tick(); expect_out("wrap_first", 16'h0001, 1'b1, 32'hA0000000, 4'd0, 1'b0, 16'd8);
      chk("model_wrap_first", m_gnt, 16'h0001);
      tick(); expect_out("wrap_second", 16'h8000, 1'b1, 32'hF000000F, 4'd15, 1'b0, 16'd9);
      chk("model_wrap_second", m_gnt, 16'h8000);
      req = '0;
      tick();

      // Misrouted word from FIFO 4 (BID 7), then a legal grant to FIFO 6.
      set_word(4, 4'd7, 32'hBAD00004);
      set_word(6, 4'd2, 32'h66666666);
      req = 16'h0010;
      tick(); expect_out("misroute", 16'h0010, 1'b0, 32'h0, 4'h0, 1'b1, 16'd10);
      chk("model_misroute_err", m_err, 1'b1);
      req = 16'h0040;
      tick(); expect_out("after_mis", 16'h0040, 1'b1, 32'h66666666, 4'd6, 1'b1, 16'd11);
      req = '0;
      tick(); expect_out("err_sticky", 16'h0, 1'b0, 32'h0, 4'h0, 1'b1, 16'd11);

      // Reset asserted while an access is stalled.
      set_word(1, 4'd2, 32'h11111111);
      req = 16'h0002;
      bank_ready = 1'b0;
      tick(); expect_out("pre_rst", 16'h0002, 1'b1, 32'h11111111, 4'd1, 1'b1, 16'd12);
      req = '0;
      tick(); expect_out("pre_rst_stall", 16'h0, 1'b1, 32'h11111111, 4'd1, 1'b1, 16'd12);
      rst_n = 1'b0;
      #1;
      expect_out("rst_async", 16'h0, 1'b0, 32'h0, 4'h0, 1'b0, 16'd0);
      chk("rst_async_data", bank_data, 32'h0);
      chk("rst_async_src", bank_src, 4'h0);
      tick();
      rst_n = 1'b1;
      req = 16'h0003;
      bank_ready = 1'b1;
      tick(); expect_out("post_rst1", 16'h0001, 1'b1, 32'hA0000000, 4'd0, 1'b0, 16'd1);
      tick(); expect_out("post_rst2", 16'h0002, 1'b1, 32'h11111111, 4'd1, 1'b0, 16'd2);
      req = '0;
      tick();

      // Randomized traffic, checked by the per-cycle compare process.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            logic [3:0] bid;
            bid = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(BANK);
            set_word(i, bid, $urandom);
         end
         case ($urandom_range(0, 3))
            0:       req = 16'($urandom);
            1:       req = 16'hFFFF;
            default: req = 16'($urandom & $urandom & $urandom);
         endcase
         bank_ready = ($urandom_range(0, 3) != 0);
         rst_n = !(n == 1500);
         tick();
      end
      rst_n = 1'b1;
      req = '0;
      bank_ready = 1'b1;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
